// File: rtl/mux_4_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_4_1_rr_arbiter
//
// Round-robin arbiter and select sequencer for a shared 4:1 multiplexer.
// Four requesters compete for one W-bit output. One requester is granted at a
// time. A grant is bounded by a time slice of SLICE_CYCLES cycles whenever
// another requester is waiting. An uncontested owner keeps the grant
// indefinitely.
//
// Ports:
//   CLOCK_50  in   1   sole clock, rising edge
//   RESET_N   in   1   asynchronous active-low reset
//   req       in   4   request vector, bit i = requester i wants the mux
//   d0..d3    in   W   data of requester 0..3 (not registered)
//   gnt       out  4   one-hot grant (registered), zero when idle
//   sel       out  2   mux select (registered), current or last owner
//   valid     out  1   |gnt
//   y         out  W   d[sel] when valid, otherwise 0 (combinational)
// -----------------------------------------------------------------------------
module mux_4_1_rr_arbiter #(
  parameter int W            = 2,
  parameter int SLICE_CYCLES = 4   // legal range 1..255
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         valid,
  output logic [W-1:0] y
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Last cycle index of a slice; the counter saturates here.
  localparam logic [7:0] CNT_MAX = 8'(SLICE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_next;
  logic [1:0] r_sel;
  logic [1:0] w_sel_next;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;

  logic [3:0] w_others;
  logic [1:0] w_pick_req;
  logic [1:0] w_pick_oth;

  // First set bit of mask scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // The loop runs from the farthest position down so the nearest one wins.
  // The result is only meaningful when mask is non-zero.
  function automatic logic [1:0] pick(input logic [3:0] mask,
                                      input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    res = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign w_others   = req & ~onehot(r_sel);
  assign w_pick_req = pick(req, r_ptr);
  assign w_pick_oth = pick(w_others, r_ptr);

  // State register: all arbitration state updates together.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd3;   // requester 0 is scanned first after reset
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_sel   <= w_sel_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_sel_next   = r_sel;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_next = S_GRANT;
          w_gnt_next   = onehot(w_pick_req);
          w_sel_next   = w_pick_req;
          w_ptr_next   = w_pick_req;
          w_cnt_next   = 8'd0;
        end
      end
      S_GRANT: begin
        if (!req[r_sel] || (r_cnt == CNT_MAX && |w_others)) begin
          if (|w_others) begin
            // Owner released or slice expired: hand over with no idle bubble.
            w_gnt_next = onehot(w_pick_oth);
            w_sel_next = w_pick_oth;
            w_ptr_next = w_pick_oth;
            w_cnt_next = 8'd0;
          end else begin
            // Owner released and nobody else waits; sel keeps the last owner.
            w_state_next = S_IDLE;
            w_gnt_next   = 4'b0000;
            w_cnt_next   = 8'd0;
          end
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = 4'b0000;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Output logic: the data path is not registered so y follows the owner's
  // data within the same cycle.
  always_comb begin
    y = '0;
    if (valid) begin
      case (r_sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = |r_gnt;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_4_1_rr_arbiter
//
// Directed bench for mux_4_1_rr_arbiter. Two instances share clock, reset and
// data: u_dut0 with SLICE_CYCLES=4 and u_dut1 with SLICE_CYCLES=1. Stimulus
// pushes hand-computed expected outputs, stamped with the cycle they apply to,
// into a queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_mux_4_1_rr_arbiter;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [3:0] req0;
  logic [3:0] req1;
  logic [1:0] d0;
  logic [1:0] d1;
  logic [1:0] d2;
  logic [1:0] d3;
  logic [3:0] gnt0;
  logic [1:0] sel0;
  logic       valid0;
  logic [1:0] y0;
  logic [3:0] gnt1;
  logic [1:0] sel1;
  logic       valid1;
  logic [1:0] y1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] y;
    string      name;
  } exp_t;

  exp_t sb[$];

  mux_4_1_rr_arbiter #(.W(2), .SLICE_CYCLES(4)) u_dut0 (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .req      (req0),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .gnt      (gnt0),
    .sel      (sel0),
    .valid    (valid0),
    .y        (y0)
  );

  mux_4_1_rr_arbiter #(.W(2), .SLICE_CYCLES(1)) u_dut1 (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .req      (req1),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .gnt      (gnt1),
    .sel      (sel1),
    .valid    (valid1),
    .y        (y1)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: compares every expectation whose stamp has come due.
  always @(negedge CLOCK_50) begin : monitor
    exp_t       e;
    logic [3:0] ag;
    logic [1:0] as;
    logic       av;
    logic [1:0] ay;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        ag = gnt0; as = sel0; av = valid0; ay = y0;
      end else begin
        ag = gnt1; as = sel1; av = valid1; ay = y1;
      end
      checks++;
      if (e.cyc != cyc || ag !== e.gnt || as !== e.sel || av !== e.valid || ay !== e.y) begin
        errors++;
        $display("FAIL %s dut%0d cyc=%0d (due %0d): got gnt=%b sel=%0d valid=%b y=%b, expected gnt=%b sel=%0d valid=%b y=%b",
                 e.name, e.dut, cyc, e.cyc, ag, as, av, ay, e.gnt, e.sel, e.valid, e.y);
      end else begin
        $display("ok   %s dut%0d cyc=%0d gnt=%b sel=%0d valid=%b y=%b",
                 e.name, e.dut, cyc, ag, as, av, ay);
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_out(input int ahead, input int dut, input logic [3:0] g,
                            input logic [1:0] s, input logic v, input logic [1:0] yy,
                            input string nm);
    exp_t e;
    e.cyc   = cyc + ahead;
    e.dut   = dut;
    e.gnt   = g;
    e.sel   = s;
    e.valid = v;
    e.y     = yy;
    e.name  = nm;
    sb.push_back(e);
  endtask

  // Nominal data values used while checking rotations.
  function automatic logic [1:0] dval(input int idx);
    case (idx)
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int owner;
    RESET_N = 1'b0;
    req0    = 4'b0000;
    req1    = 4'b0000;
    d0      = 2'b01;
    d1      = 2'b10;
    d2      = 2'b11;
    d3      = 2'b11;

    repeat (3) step();
    expect_out(0, 0, 4'b0000, 2'd0, 1'b0, 2'b00, "reset_u0");
    expect_out(0, 1, 4'b0000, 2'd0, 1'b0, 2'b00, "reset_u1");
    RESET_N = 1'b1;

    // 1: idle after reset release
    for (int i = 1; i <= 10; i++)
      expect_out(i, 0, 4'b0000, 2'd0, 1'b0, 2'b00, "t1_idle");
    repeat (10) step();

    // 2: two requesters alternate in slices of four, no gap
    req0 = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      owner = ((k - 1) / 4) % 2;
      expect_out(k, 0, 4'b0001 << owner, 2'(owner), 1'b1, dval(owner), "t2_rotate");
    end
    repeat (16) step();

    // 3: uncontested owner keeps grant, then saturated slice preempts at once
    req0 = 4'b0100;
    for (int k = 1; k <= 20; k++)
      expect_out(k, 0, 4'b0100, 2'd2, 1'b1, 2'b11, "t3_solo");
    repeat (20) step();
    req0 = 4'b0101;
    expect_out(1, 0, 4'b0001, 2'd0, 1'b1, 2'b01, "t3_preempt");
    step();

    // 4: owner drop skips idle requesters, y tracks data, idle keeps sel
    req0 = 4'b0010;
    expect_out(1, 0, 4'b0010, 2'd1, 1'b1, 2'b10, "t4_to1");
    step();
    req0 = 4'b1001;
    expect_out(1, 0, 4'b1000, 2'd3, 1'b1, 2'b11, "t4_skip_to3");
    step();
    step();
    d3 = 2'b10;
    expect_out(0, 0, 4'b1000, 2'd3, 1'b1, 2'b10, "t4_y_follows_data");
    req0 = 4'b0000;
    expect_out(1, 0, 4'b0000, 2'd3, 1'b0, 2'b00, "t4_idle");
    expect_out(2, 0, 4'b0000, 2'd3, 1'b0, 2'b00, "t4_idle_hold");
    step();
    step();
    d3 = 2'b11;

    // 5: SLICE_CYCLES=1 rotates every cycle among four requesters
    req1 = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      owner = (k - 1) % 4;
      expect_out(k, 1, 4'b0001 << owner, 2'(owner), 1'b1, dval(owner), "t5_slice1");
    end
    repeat (8) step();

    // 6: asynchronous reset mid-grant, restart from requester 0
    req0 = 4'b0100;
    expect_out(1, 0, 4'b0100, 2'd2, 1'b1, 2'b11, "t6_own2");
    step();
    step();
    #1;
    RESET_N = 1'b0;
    expect_out(0, 0, 4'b0000, 2'd0, 1'b0, 2'b00, "t6_async_u0");
    expect_out(0, 1, 4'b0000, 2'd0, 1'b0, 2'b00, "t6_async_u1");
    step();
    RESET_N = 1'b1;
    req0 = 4'b1111;
    expect_out(0, 0, 4'b0000, 2'd0, 1'b0, 2'b00, "t6_released");
    expect_out(1, 0, 4'b0001, 2'd0, 1'b1, 2'b01, "t6_first_u0");
    expect_out(1, 1, 4'b0001, 2'd0, 1'b1, 2'b01, "t6_first_u1");
    expect_out(2, 0, 4'b0001, 2'd0, 1'b1, 2'b01, "t6_hold_u0");
    expect_out(2, 1, 4'b0010, 2'd1, 1'b1, 2'b10, "t6_rot_u1");
    repeat (3) step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for a shared 4:1 multiplexer with W-bit data.
- Four requesters compete for the single mux output. The block grants one requester at a time, drives the mux select and returns the selected data.
- Each grant is bounded by a time slice, so no requester can hold the resource while another is waiting.
- Sits between board inputs (switches/keys, or upstream logic) and a shared output such as LEDR.

Parameters:
- W, 2, data width of each mux input and of y.
- SLICE_CYCLES, 4, maximum consecutive cycles one requester keeps the grant while another requester is pending. Legal range 1..255.

Ports:
- CLOCK_50  input  1  sole clock; rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i wants the mux.
- d0  input  W  data of requester 0.
- d1  input  W  data of requester 1.
- d2  input  W  data of requester 2.
- d3  input  W  data of requester 3.
- gnt  output  4  one-hot grant (registered); all zero when idle.
- sel  output  2  mux select (registered); index of the current or last owner.
- valid  output  1  high when any grant is active (equals |gnt).
- y  output  W  combinational output: d[sel] when valid, otherwise 0.

Behaviour:
- Reset (RESET_N low, async, takes effect immediately):
  - state=IDLE, gnt=0, sel=0, valid=0, y=0, cnt=0.
  - Priority pointer ptr=3, so requester 0 wins first after reset.
- Arbitration function pick(mask): first set bit of mask, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- State IDLE:
  - If req != 0: next cycle gnt = onehot(pick(req)), sel = pick(req), ptr = pick(req), cnt = 0, state = GRANT.
  - If req == 0: outputs stay idle.
  - Latency: one cycle from req sampled to gnt high.
- State GRANT (owner = sel):
  - cnt counts cycles in the current grant, starting at 0 and saturating at SLICE_CYCLES-1.
  - others = req with bit sel cleared.
  - req[sel]==0 and others!=0: hand over to pick(others) at the next edge. No idle bubble. cnt=0, ptr=new owner.
  - req[sel]==0 and others==0: next cycle state=IDLE, gnt=0, valid=0. sel holds its last value.
  - req[sel]==1 and cnt==SLICE_CYCLES-1 and others!=0: preempt and hand over to pick(others). Under contention the owner therefore holds gnt for exactly SLICE_CYCLES cycles.
  - req[sel]==1 otherwise: keep grant; cnt <= min(cnt+1, SLICE_CYCLES-1).
  - An uncontested owner keeps the grant indefinitely. If a competitor later appears after saturation, the owner is preempted at the next edge.
- SLICE_CYCLES==1: a contested grant rotates every cycle.
- gnt is always zero or one-hot. gnt[i] never rises unless req[i] was high at the preceding edge.
- A requester that drops req while not owner loses nothing; its position in the rotation depends only on ptr.
- cnt width: 8 bits.
- Reset mid-grant: gnt clears asynchronously; after release, arbitration restarts from requester 0.
- d0..d3 are not registered. y follows data changes of the owner within the same cycle.

Test Plan:
1. Reset release with req=4'b0000 -> gnt=0, valid=0, y=0, sel=0 for 10 cycles.
2. req=4'b0011 held, SLICE_CYCLES=4, d0=2'b01, d1=2'b10 -> gnt=0001 for 4 cycles with y=01, then gnt=0010 for 4 cycles with y=10, repeating. No cycle with gnt=0.
3. req=4'b0100 alone for 20 cycles, then req=4'b0101 -> gnt=0100 throughout; cnt is saturated, so 1 cycle after req[0] appears gnt=0001.
4. Owner 1 drops req while req=4'b1001 -> next cycle gnt=1000 (pointer after 1 is 2, 3, 0, 1). Then req=4'b0000 -> gnt=0 next cycle, sel stays 3, y=0.
5. All four requesting, SLICE_CYCLES=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 … one per cycle.
6. RESET_N pulsed low mid-grant (owner 2) -> gnt=0 within the low pulse without a clock edge. After release with req=4'b1111, the first grant is 0001.
